// File: rtl/mem_io_bridge.sv
// Multi-cycle load/store bridge from the CPU to data memory or memory-mapped IO channels.
// The CPU is stalled until the selected target completes. Errors are reported on bus_err.
module mem_io_bridge #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       IO_W      = 16,
    parameter int unsigned       IO_CH     = 4,
    parameter logic [DATA_W-1:0] IO_BASE   = 32'hFFFF_FC00,
    parameter int unsigned       IO_STRIDE = 16,
    parameter int unsigned       MEM_LAT   = 2,
    parameter int unsigned       TIMEOUT   = 255,
    parameter bit                SIGN_EXT  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mRead,
    input  logic                  mWrite,
    input  logic [DATA_W-1:0]     addr_in,
    input  logic [DATA_W-1:0]     r_rdata,
    output logic [DATA_W-1:0]     r_wdata,
    output logic                  stall,
    output logic                  bus_err,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [IO_CH-1:0]      io_sel,
    output logic                  io_re,
    output logic                  io_we,
    output logic [IO_W-1:0]       io_wdata,
    input  logic [IO_CH*IO_W-1:0] io_rdata,
    input  logic [IO_CH-1:0]      io_ready
);

    localparam int unsigned ChW      = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam int unsigned CntMax   = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
    localparam int unsigned CntW     = $clog2(CntMax + 1);
    localparam int unsigned StrideSh = $clog2(IO_STRIDE);

    typedef enum logic [1:0] {StIdle, StMemWait, StIoWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ChW-1:0]      ch_q, ch_d;
    logic                is_rd_q, is_rd_d;
    logic [IO_CH-1:0]    io_sel_q, io_sel_d;
    logic                io_re_q, io_re_d;
    logic                io_we_q, io_we_d;
    logic [DATA_W-1:0]   r_wdata_q, r_wdata_d;
    logic                bus_err_q, bus_err_d;

    logic                req;
    logic                idle_live;
    logic                in_io;
    logic                io_mapped;
    logic [DATA_W-1:0]   io_offset;
    logic [DATA_W-1:0]   ch_full;
    logic [IO_W-1:0]     io_word;
    logic [DATA_W-1:0]   io_ext;

    // Address decode of the request currently presented by the CPU.
    always_comb begin
        req       = mRead | mWrite;
        idle_live = (state_q == StIdle) & ~rst;
        in_io     = (addr_in >= IO_BASE);
        io_offset = addr_in - IO_BASE;
        ch_full   = io_offset >> StrideSh;
        io_mapped = in_io & (ch_full < DATA_W'(IO_CH));
    end

    always_comb begin
        io_word = io_rdata[ch_q*IO_W +: IO_W];
        if (SIGN_EXT) begin
            io_ext = DATA_W'($signed(io_word));
        end else begin
            io_ext = DATA_W'(io_word);
        end
    end

    // Memory strobes belong to the accepting cycle, so they are decoded directly;
    // gating with rst makes them drop as soon as reset asserts.
    always_comb begin
        stall     = ~rst & req & (state_q != StDone);
        mem_re    = idle_live & req & ~mWrite & ~in_io;
        mem_we    = idle_live & mWrite & ~in_io;
        mem_addr  = idle_live ? addr_in : addr_q;
        mem_wdata = idle_live ? r_rdata : wdata_q;
        io_sel    = io_sel_q;
        io_re     = io_re_q;
        io_we     = io_we_q;
        io_wdata  = wdata_q[IO_W-1:0];
        r_wdata   = r_wdata_q;
        bus_err   = bus_err_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ch_d      = ch_q;
        is_rd_d   = is_rd_q;
        io_sel_d  = io_sel_q;
        io_re_d   = io_re_q;
        io_we_d   = io_we_q;
        r_wdata_d = r_wdata_q;
        bus_err_d = bus_err_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d    = addr_in;
                    wdata_d   = r_rdata;
                    is_rd_d   = ~mWrite;
                    ch_d      = ch_full[ChW-1:0];
                    bus_err_d = 1'b0;
                    if (!in_io) begin
                        if (mWrite) begin
                            state_d = StDone;
                        end else begin
                            cnt_d   = CntW'(MEM_LAT - 1);
                            state_d = StMemWait;
                        end
                    end else if (io_mapped) begin
                        cnt_d    = CntW'(TIMEOUT - 1);
                        io_sel_d = IO_CH'(1) << ch_full[ChW-1:0];
                        io_re_d  = ~mWrite;
                        io_we_d  = mWrite;
                        state_d  = StIoWait;
                    end else begin
                        bus_err_d = 1'b1;
                        if (!mWrite) begin
                            r_wdata_d = '0;
                        end
                        state_d = StDone;
                    end
                end
            end
            StMemWait: begin
                if (cnt_q == '0) begin
                    r_wdata_d = mem_rdata;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StIoWait: begin
                // Ready wins over timeout, so a ready on the last counted cycle succeeds.
                if (io_ready[ch_q]) begin
                    io_sel_d = '0;
                    io_re_d  = 1'b0;
                    io_we_d  = 1'b0;
                    if (is_rd_q) begin
                        r_wdata_d = io_ext;
                    end
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    io_sel_d  = '0;
                    io_re_d   = 1'b0;
                    io_we_d   = 1'b0;
                    bus_err_d = 1'b1;
                    if (is_rd_q) begin
                        r_wdata_d = '0;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ch_q      <= '0;
            is_rd_q   <= 1'b0;
            io_sel_q  <= '0;
            io_re_q   <= 1'b0;
            io_we_q   <= 1'b0;
            r_wdata_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ch_q      <= ch_d;
            is_rd_q   <= is_rd_d;
            io_sel_q  <= io_sel_d;
            io_re_q   <= io_re_d;
            io_we_q   <= io_we_d;
            r_wdata_q <= r_wdata_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed plus randomized checks of mem_io_bridge against a transaction-level model.
// A second instance with zero-extension shares all inputs; only its load data is checked.
module tb_mem_io_bridge;

    localparam int unsigned    DW   = 32;
    localparam int unsigned    IW   = 16;
    localparam int unsigned    NCH  = 4;
    localparam int unsigned    STR  = 16;
    localparam int unsigned    LAT  = 2;
    localparam int unsigned    TMO  = 4;
    localparam logic [DW-1:0]  BASE = 32'hFFFF_FC00;

    logic              clk = 1'b0;
    logic              rst;
    logic              mRead, mWrite;
    logic [DW-1:0]     addr_in, r_rdata, r_wdata;
    logic              stall, bus_err;
    logic [DW-1:0]     mem_addr, mem_wdata, mem_rdata;
    logic              mem_re, mem_we;
    logic [NCH-1:0]    io_sel, io_ready;
    logic              io_re, io_we;
    logic [IW-1:0]     io_wdata;
    logic [NCH*IW-1:0] io_rdata;

    logic [DW-1:0]     z_r_wdata, z_mem_addr, z_mem_wdata;
    logic              z_stall, z_bus_err, z_mem_re, z_mem_we, z_io_re, z_io_we;
    logic [NCH-1:0]    z_io_sel;
    logic [IW-1:0]     z_io_wdata;

    int                checks = 0;
    int                failures = 0;
    string             step = "init";
    logic [DW-1:0]     exp_rd = '0;
    logic [DW-1:0]     exp_rd_z = '0;
    logic              exp_err = 1'b0;

    always #5 clk = ~clk;

    mem_io_bridge #(
        .DATA_W(DW), .IO_W(IW), .IO_CH(NCH), .IO_BASE(BASE), .IO_STRIDE(STR),
        .MEM_LAT(LAT), .TIMEOUT(TMO), .SIGN_EXT(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .mRead(mRead), .mWrite(mWrite), .addr_in(addr_in),
        .r_rdata(r_rdata), .r_wdata(r_wdata), .stall(stall), .bus_err(bus_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .io_sel(io_sel), .io_re(io_re), .io_we(io_we),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ready(io_ready)
    );

    mem_io_bridge #(
        .DATA_W(DW), .IO_W(IW), .IO_CH(NCH), .IO_BASE(BASE), .IO_STRIDE(STR),
        .MEM_LAT(LAT), .TIMEOUT(TMO), .SIGN_EXT(1'b0)
    ) u_dut_z (
        .clk(clk), .rst(rst), .mRead(mRead), .mWrite(mWrite), .addr_in(addr_in),
        .r_rdata(r_rdata), .r_wdata(z_r_wdata), .stall(z_stall), .bus_err(z_bus_err),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_re(z_mem_re),
        .mem_we(z_mem_we), .mem_rdata(mem_rdata), .io_sel(z_io_sel), .io_re(z_io_re),
        .io_we(z_io_we), .io_wdata(z_io_wdata), .io_rdata(io_rdata), .io_ready(io_ready)
    );

    // Memory model: data is valid only in the cycle exactly LAT edges after the read strobe.
    function automatic logic [DW-1:0] mem_fn(input logic [DW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    logic          mem_pend = 1'b0;
    int            mem_age = 0;
    logic [DW-1:0] mem_raddr = '0;

    always @(posedge clk) begin
        if (mem_re) begin
            mem_pend  <= 1'b1;
            mem_age   <= 0;
            mem_raddr <= mem_addr;
        end else if (mem_pend) begin
            mem_age <= mem_age + 1;
        end
    end

    assign mem_rdata = (mem_pend && mem_age == int'(LAT) - 1) ? mem_fn(mem_raddr)
                                                               : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s [%s] observed=%h expected=%h", tag, step, obs, exp);
        end
    endtask

    // One complete access. d = index of the first IO_WAIT cycle with ready asserted.
    task automatic access(input bit rd, input bit wr, input logic [DW-1:0] a,
                          input logic [DW-1:0] wd, input int d, input logic [IW-1:0] ival);
        logic           in_io;
        logic [DW-1:0]  off;
        int             ch;
        bit             mapped, err, io_act;
        int             s;
        logic [NCH-1:0] sel, nz;
        in_io  = (a >= BASE);
        off    = a - BASE;
        ch     = in_io ? int'(off / STR) : 0;
        mapped = in_io && ch < int'(NCH);
        sel    = '0;
        if (mapped) sel[ch] = 1'b1;
        if (!in_io)          s = wr ? 1 : int'(LAT) + 1;
        else if (!mapped)    s = 1;
        else if (d < int'(TMO)) s = d + 2;
        else                 s = int'(TMO) + 1;
        err = in_io && (!mapped || d >= int'(TMO));
        for (int c = 0; c < int'(NCH); c++) io_rdata[c*IW +: IW] = IW'($urandom);
        if (mapped) io_rdata[ch*IW +: IW] = ival;
        if (!wr) begin
            if (err) begin
                exp_rd = '0; exp_rd_z = '0;
            end else if (!in_io) begin
                exp_rd = mem_fn(a); exp_rd_z = mem_fn(a);
            end else begin
                exp_rd = {{16{ival[15]}}, ival}; exp_rd_z = {16'h0, ival};
            end
        end
        exp_err = err;
        for (int k = 0; k <= s; k++) begin
            @(negedge clk);
            mRead = rd; mWrite = wr; addr_in = a; r_rdata = wd;
            nz = NCH'($urandom);
            io_ready = (nz & ~sel) | ((mapped && k >= 1 && k - 1 >= d) ? sel : '0);
            #1;
            chk("stall", stall, k < s);
            chk("mem_re", mem_re, !in_io && !wr && k == 0);
            chk("mem_we", mem_we, !in_io && wr && k == 0);
            if (!in_io && k == 0) begin
                chk("mem_addr", mem_addr, a);
                if (wr) chk("mem_wdata", mem_wdata, wd);
            end
            io_act = mapped && k >= 1 && k < s;
            chk("io_sel", io_sel, io_act ? sel : '0);
            chk("io_re", io_re, io_act && !wr);
            chk("io_we", io_we, io_act && wr);
            if (io_act) chk("io_wdata", io_wdata, wd[IW-1:0]);
            if (k == s) begin
                chk("r_wdata", r_wdata, exp_rd);
                chk("r_wdata_zext", z_r_wdata, exp_rd_z);
                chk("bus_err", bus_err, err);
            end else if (k >= 1) begin
                chk("bus_err_clr", bus_err, 1'b0);
            end
        end
        @(negedge clk);
        mRead = 1'b0; mWrite = 1'b0; io_ready = '0;
        #1;
        chk("idle_stall", stall, 1'b0);
        chk("idle_r_wdata", r_wdata, exp_rd);
        chk("idle_bus_err", bus_err, exp_err);
    endtask

    // Starts an access, lets it run n cycles, then pulses reset mid-cycle.
    task automatic reset_mid(input bit wr, input logic [DW-1:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mRead = ~wr; mWrite = wr; addr_in = a; r_rdata = $urandom; io_ready = '0;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_io_re", io_re, 1'b0);
        chk("rst_io_we", io_we, 1'b0);
        chk("rst_io_sel", io_sel, '0);
        chk("rst_r_wdata", r_wdata, '0);
        @(negedge clk);
        rst = 1'b0; mRead = 1'b0; mWrite = 1'b0;
        exp_rd = '0; exp_rd_z = '0; exp_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mRead = 1'b0; mWrite = 1'b0; addr_in = '0; r_rdata = '0;
        io_ready = '0; io_rdata = '0;
        #2;
        step = "reset";
        chk("rst_stall", stall, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_r_wdata", r_wdata, '0);
        chk("rst_io_sel", io_sel, '0);
        chk("rst_io_we", io_we, 1'b0);
        mRead = 1'b1; addr_in = 32'h100;
        #1;
        chk("rst_req_stall", stall, 1'b0);
        chk("rst_req_mem_re", mem_re, 1'b0);
        @(negedge clk);
        mRead = 1'b0;
        rst = 1'b0;

        step = "mem_read";      access(1, 0, 32'h4110_84F7, 32'h0, 0, 16'h0);
        chk("deadbeef", r_wdata, 32'hDEAD_BEEF);
        step = "mem_write";     access(0, 1, 32'h10, 32'h1234_5678, 0, 16'h0);
        step = "io_read_ch2";   access(1, 0, BASE + 32'h20, 32'h0, 2, 16'h8001);
        chk("sext", r_wdata, 32'hFFFF_8001);
        chk("zext", z_r_wdata, 32'h0000_8001);
        step = "io_write_tmo";  access(0, 1, BASE + 32'h10, 32'hCAFE_F00D, 99, 16'h0);
        step = "clear_err";     access(0, 1, 32'h20, 32'h5555_AAAA, 0, 16'h0);
        step = "unmapped";      access(1, 0, BASE + 32'h40, 32'h0, 0, 16'h1234);
        step = "last_cycle_ok"; access(1, 0, BASE + 32'h34, 32'h0, TMO - 1, 16'h7F0F);
        step = "tmo_read";      access(1, 0, BASE + 32'h0, 32'h0, TMO, 16'hABCD);
        step = "rd_and_wr";     access(1, 1, 32'h80, 32'h0BAD_F00D, 0, 16'h0);
        step = "rst_memwait";   reset_mid(0, 32'h200, 2);
        step = "after_rst_mem"; access(1, 0, 32'h204, 32'h0, 0, 16'h0);
        step = "rst_iowait";    reset_mid(0, BASE + 32'h30, 3);
        step = "after_rst_io";  access(1, 0, BASE + 32'h30, 32'h0, 1, 16'h9999);

        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] a;
            int            op;
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom & 32'h7FFF_FFFC;
            end else begin
                a = BASE + 32'($urandom_range(0, 5) * STR + $urandom_range(0, STR - 1));
            end
            step = $sformatf("rand%0d", i);
            access(op != 1, op != 0, a, $urandom, $urandom_range(0, 6), IW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog [%s] observed=running expected=finished", step);
        $fatal(1, "timeout");
    end

endmodule
